// File: rtl/onehot_encoder.sv
// Debounced 4-to-2 one-hot encoder with a valid/ready output handshake.
// Optional macro ENC_PRIORITY_EN: multi-hot patterns encode to the highest set index instead of flagging err.
module onehot_encoder #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic ready,
  output logic out0,
  output logic out1,
  output logic valid,
  output logic err
);

  localparam logic [7:0] DB = 8'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, RELEASE} state_t;

  state_t     state, state_nxt;
  logic [3:0] sync_p0, sync_p1;
  logic [3:0] pat, pat_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] code_p2, code_nxt;
  logic       err_p2, err_nxt;
  logic       vld_p2, vld_nxt;
  logic [2:0] enc;
  logic [3:0] s;

  // Returns {err, code} for a nonzero captured pattern.
  function automatic logic [2:0] encode(input logic [3:0] p);
    logic [2:0] r;
`ifdef ENC_PRIORITY_EN
    casez (p)
      4'b1???: r = 3'b011;
      4'b01??: r = 3'b010;
      4'b001?: r = 3'b001;
      default: r = 3'b000;
    endcase
`else
    case (p)
      4'b0001: r = 3'b000;
      4'b0010: r = 3'b001;
      4'b0100: r = 3'b010;
      4'b1000: r = 3'b011;
      default: r = 3'b100;
    endcase
`endif
    return r;
  endfunction

  assign s   = sync_p1;
  assign enc = encode(pat);

  // Stage p0/p1: two-flop synchroniser; p2: FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      state   <= IDLE;
      pat     <= '0;
      cnt     <= '0;
      code_p2 <= '0;
      err_p2  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      sync_p0 <= {in3, in2, in1, in0};
      sync_p1 <= sync_p0;
      state   <= state_nxt;
      pat     <= pat_nxt;
      cnt     <= cnt_nxt;
      code_p2 <= code_nxt;
      err_p2  <= err_nxt;
      vld_p2  <= vld_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pat_nxt   = pat;
    cnt_nxt   = cnt;
    code_nxt  = code_p2;
    err_nxt   = err_p2;
    vld_nxt   = vld_p2;
    case (state)
      IDLE: begin
        if (s != 4'b0000) begin
          pat_nxt   = s;
          cnt_nxt   = 8'd1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (s == 4'b0000) begin
          state_nxt = IDLE;
        end else if (s != pat) begin
          pat_nxt = s;
          cnt_nxt = 8'd1;
        end else if (cnt == DB) begin
          code_nxt  = enc[1:0];
          err_nxt   = enc[2];
          vld_nxt   = 1'b1;
          state_nxt = EMIT;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      EMIT: begin
        // Code is frozen here; only the handshake moves us on.
        if (ready) begin
          vld_nxt   = 1'b0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (s == 4'b0000) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out0  = code_p2[0];
  assign out1  = code_p2[1];
  assign valid = vld_p2;
  assign err   = err_p2;

endmodule
